// File: rtl/mmio_timer.sv
// Byte-addressed 64-bit timer peripheral with compare interrupt.
// Reads of mtime byte 0 snapshot the upper bytes so a multi-byte read is never torn.
module mmio_timer #(
   parameter int ADDR_WIDTH = 5,
   parameter int PRESCALE   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rdy_in,
   input  logic                  en_in,
   input  logic                  r_nw_in,
   input  logic [ADDR_WIDTH-1:0] a_in,
   input  logic [7:0]            d_in,
   output logic [7:0]            d_out,
   input  logic                  irq_ack_in,
   output logic                  timer_interrupt
);

   localparam logic [15:0]           PCNT_LAST   = 16'(PRESCALE - 1);
   localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(16);
   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(17);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] mtime_next;
   logic [63:8] shadow;
   logic [63:0] shadow_full;
   logic [15:0] pcnt;
   logic [1:0]  ctrl;
   logic        pending;
   logic        match_q;
   logic        rd_en;
   logic        wr_en;
   logic        sel_mtime;
   logic        sel_cmp;
   logic        sel_ctrl;
   logic        sel_status;
   logic [2:0]  byte_sel;
   logic        advance;
   logic        tick;
   logic        match;
   logic        match_rise;
   logic        irq_clear;
   logic [7:0]  rd_data;

   assign rd_en       = en_in & r_nw_in;
   assign wr_en       = en_in & ~r_nw_in;
   assign byte_sel    = a_in[2:0];
   assign sel_mtime   = (a_in >> 3) == ADDR_WIDTH'(0);
   assign sel_cmp     = (a_in >> 3) == ADDR_WIDTH'(1);
   assign sel_ctrl    = a_in == CTRL_ADDR;
   assign sel_status  = a_in == STATUS_ADDR;
   assign shadow_full = {shadow, 8'h00};

   assign advance    = ctrl[0] & rdy_in;
   assign tick       = advance & (pcnt == PCNT_LAST);
   assign match      = mtime >= mtimecmp;
   assign match_rise = match & ~match_q & ctrl[1];
   assign irq_clear  = irq_ack_in | (wr_en & sel_status & d_in[0]);

   // A bus write to an mtime byte overrides the increment of the same cycle.
   always_comb begin
      mtime_next = tick ? mtime + 64'd1 : mtime;
      if (wr_en && sel_mtime) begin
         mtime_next = mtime;
         mtime_next[{byte_sel, 3'b000} +: 8] = d_in;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (sel_mtime)
         rd_data = (byte_sel == 3'd0) ? mtime[7:0] : shadow_full[{byte_sel, 3'b000} +: 8];
      else if (sel_cmp)
         rd_data = mtimecmp[{byte_sel, 3'b000} +: 8];
      else if (sel_ctrl)
         rd_data = {6'b0, ctrl};
      else if (sel_status)
         rd_data = {7'b0, pending};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime    <= '0;
         mtimecmp <= '1;
         ctrl     <= '0;
         pcnt     <= '0;
      end else begin
         mtime <= mtime_next;
         if (advance)
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
         if (wr_en && sel_cmp)
            mtimecmp[{byte_sel, 3'b000} +: 8] <= d_in;
         if (wr_en && sel_ctrl)
            ctrl <= d_in[1:0];
      end
   end

   // Rewriting mtimecmp re-arms the edge detector so an already-passed compare fires again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_q         <= 1'b0;
         pending         <= 1'b0;
         timer_interrupt <= 1'b0;
      end else begin
         match_q <= (wr_en && sel_cmp) ? 1'b0 : match;
         if (match_rise)
            pending <= 1'b1;
         else if (irq_clear)
            pending <= 1'b0;
         timer_interrupt <= pending & ctrl[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_out  <= 8'h00;
         shadow <= '0;
      end else if (rd_en) begin
         d_out <= rd_data;
         if (sel_mtime && byte_sel == 3'd0)
            shadow <= mtime[63:8];
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: one instance at PRESCALE=4, one at PRESCALE=1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mmio_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rdy_in = 1'b1;
   logic       en_p4 = 1'b0;
   logic       en_p1 = 1'b0;
   logic       r_nw = 1'b1;
   logic [4:0] a = 5'd0;
   logic [7:0] d = 8'd0;
   logic       irq_ack = 1'b0;
   logic [7:0] d_out_p4;
   logic [7:0] d_out_p1;
   logic       irq_p4;
   logic       irq_p1;

   int num_checks = 0;
   int num_fails  = 0;

   always #5 clk = ~clk;

   mmio_timer #(.ADDR_WIDTH(5), .PRESCALE(4)) dut_p4 (
      .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .en_in(en_p4), .r_nw_in(r_nw),
      .a_in(a), .d_in(d), .d_out(d_out_p4), .irq_ack_in(irq_ack), .timer_interrupt(irq_p4)
   );

   mmio_timer #(.ADDR_WIDTH(5), .PRESCALE(1)) dut_p1 (
      .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .en_in(en_p1), .r_nw_in(r_nw),
      .a_in(a), .d_in(d), .d_out(d_out_p1), .irq_ack_in(irq_ack), .timer_interrupt(irq_p1)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      num_checks++;
      assert (observed === expected)
      else begin
         num_fails++;
         $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
      end
   endtask

   // One bus cycle, started and finished on a falling edge.
   task automatic applyStimulus(input logic sel_p4, input logic rnw, input logic [4:0] addr,
                                input logic [7:0] data);
      en_p4 = sel_p4;
      en_p1 = ~sel_p4;
      r_nw  = rnw;
      a     = addr;
      d     = data;
      @(negedge clk);
      en_p4 = 1'b0;
      en_p1 = 1'b0;
      r_nw  = 1'b1;
   endtask

   task automatic writeByte(input logic sel_p4, input logic [4:0] addr, input logic [7:0] data);
      applyStimulus(sel_p4, 1'b0, addr, data);
   endtask

   task automatic readCheck(input logic sel_p4, input logic [4:0] addr, input logic [7:0] expected,
                            input string tag);
      applyStimulus(sel_p4, 1'b1, addr, 8'h00);
      checkOutput(tag, sel_p4 ? d_out_p4 : d_out_p1, expected);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseAck();
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   initial begin
      logic [7:0] expected;

      $display("[TB] start");
      idle(2);
      checkOutput("reset_dout", d_out_p1, 8'h00);
      checkOutput("reset_irq", {7'b0, irq_p1}, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         expected = (i >= 8 && i < 16) ? 8'hFF : 8'h00;
         readCheck(1'b0, 5'(i), expected, $sformatf("reset_map_%0d", i));
      end
      checkOutput("reset_map_irq", {7'b0, irq_p1}, 8'h00);

      // Prescaler of 4: 40 cycles of counting gives 10 increments.
      writeByte(1'b1, 5'h10, 8'h01);
      idle(40);
      readCheck(1'b1, 5'h00, 8'h0A, "presc_byte0");
      writeByte(1'b1, 5'h12, 8'h5A);
      idle(2);
      checkOutput("dout_hold", d_out_p4, 8'h0A);
      readCheck(1'b1, 5'h01, 8'h00, "presc_byte1");
      readCheck(1'b1, 5'h07, 8'h00, "presc_byte7");

      // Snapshot across the 32-bit carry.
      for (int i = 0; i < 4; i++)
         writeByte(1'b0, 5'(i), 8'hFF);
      writeByte(1'b0, 5'h10, 8'h01);
      readCheck(1'b0, 5'h00, 8'hFF, "carry_b0");
      readCheck(1'b0, 5'h04, 8'h00, "carry_b4_snap");
      readCheck(1'b0, 5'h03, 8'hFF, "carry_b3_snap");
      readCheck(1'b0, 5'h00, 8'h02, "carry_b0_new");
      readCheck(1'b0, 5'h04, 8'h01, "carry_b4_new");
      readCheck(1'b0, 5'h03, 8'h00, "carry_b3_new");
      writeByte(1'b0, 5'h10, 8'h00);

      // Compare at 5, then acknowledge.
      for (int i = 0; i < 8; i++)
         writeByte(1'b0, 5'(i), 8'h00);
      writeByte(1'b0, 5'h08, 8'h05);
      for (int i = 9; i < 16; i++)
         writeByte(1'b0, 5'(i), 8'h00);
      writeByte(1'b0, 5'h10, 8'h03);
      checkOutput("irq_before", {7'b0, irq_p1}, 8'h00);
      idle(6);
      checkOutput("irq_pend_cycle", {7'b0, irq_p1}, 8'h00);
      idle(1);
      checkOutput("irq_rise", {7'b0, irq_p1}, 8'h01);
      pulseAck();
      idle(1);
      checkOutput("irq_ack_drop", {7'b0, irq_p1}, 8'h00);
      idle(5);
      checkOutput("irq_stays_low", {7'b0, irq_p1}, 8'h00);
      readCheck(1'b0, 5'h11, 8'h00, "status_after_ack");

      // Rewriting mtimecmp below mtime re-triggers.
      writeByte(1'b0, 5'h10, 8'h00);
      writeByte(1'b0, 5'h00, 8'h00);
      writeByte(1'b0, 5'h08, 8'd20);
      writeByte(1'b0, 5'h00, 8'd25);
      writeByte(1'b0, 5'h10, 8'h02);
      readCheck(1'b0, 5'h11, 8'h00, "no_edge_while_high");
      writeByte(1'b0, 5'h08, 8'd10);
      idle(1);
      readCheck(1'b0, 5'h11, 8'h01, "cmp_rewrite_pend");
      checkOutput("cmp_rewrite_irq", {7'b0, irq_p1}, 8'h01);
      pulseAck();
      readCheck(1'b0, 5'h11, 8'h00, "ack_clear");
      writeByte(1'b0, 5'h08, 8'd10);
      pulseAck();
      readCheck(1'b0, 5'h11, 8'h01, "set_beats_clear");

      // Write during a tick replaces the byte and drops the increment.
      writeByte(1'b0, 5'h10, 8'h00);
      writeByte(1'b0, 5'h00, 8'h10);
      writeByte(1'b0, 5'h10, 8'h01);
      writeByte(1'b0, 5'h00, 8'h33);
      readCheck(1'b0, 5'h00, 8'h33, "tick_collision");
      rdy_in = 1'b0;
      idle(8);
      readCheck(1'b0, 5'h00, 8'h34, "rdy_freeze");
      readCheck(1'b0, 5'h11, 8'h01, "masked_pending");
      checkOutput("masked_irq", {7'b0, irq_p1}, 8'h00);
      rdy_in = 1'b1;

      // Asynchronous reset while the interrupt is asserted.
      writeByte(1'b0, 5'h10, 8'h03);
      idle(1);
      checkOutput("irq_before_reset", {7'b0, irq_p1}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_irq", {7'b0, irq_p1}, 8'h00);
      checkOutput("async_reset_dout", d_out_p1, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      readCheck(1'b0, 5'h11, 8'h00, "post_reset_status");
      readCheck(1'b0, 5'h08, 8'hFF, "post_reset_cmp");
      readCheck(1'b0, 5'h10, 8'h00, "post_reset_ctrl");
      readCheck(1'b0, 5'h00, 8'h00, "post_reset_mtime");

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped 64-bit timer that responds to the CPU's byte-wide memory bus, in the peripheral address window beside RAM and the HCI I/O.
- Drives the CPU's timer_interrupt input.
- Clears that interrupt either when the CPU pulses resetInterrupt or when software writes to the status register.
- Read latency matches RAM (one cycle), so the top-level read mux is unchanged.

Parameters:
- ADDR_WIDTH, 5: width of the bus offset the block decodes.
- PRESCALE, 1: clk cycles per mtime increment; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rdy_in  input  1  system ready; 0 freezes counting (HCI debug break). Bus accesses still complete.
- en_in  input  1  chip select for this peripheral, valid in the same cycle as a_in.
- r_nw_in  input  1  1 = read, 0 = write.
- a_in  input  ADDR_WIDTH  byte offset.
- d_in  input  8  write data.
- d_out  output  8  read data, registered.
- irq_ack_in  input  1  one-cycle ack from the CPU (resetInterrupt); clears the pending interrupt.
- timer_interrupt  output  1  level interrupt to the CPU, registered.

Behaviour:
- Reset (rst_n=0, async): mtime=0, mtimecmp=all ones, ctrl=0, pending=0, prescale count=0, shadow=0, d_out=0, timer_interrupt=0.
- Register map (little-endian bytes):
  - 0x00-0x07: mtime.
  - 0x08-0x0F: mtimecmp.
  - 0x10: ctrl. bit0 = count enable, bit1 = irq enable; other bits read 0.
  - 0x11: status. bit0 = pending; write 1 clears it.
  - Other offsets: read 0x00, writes ignored.
- Read:
  - en_in=1, r_nw_in=1 in cycle N → d_out holds the byte in cycle N+1.
  - d_out holds its last value when there is no read.
- Atomic 64-bit read:
  - Reading offset 0x00 returns live byte0 and loads shadow[63:8] with mtime[63:8] in the same cycle.
  - Offsets 0x01-0x07 return shadow bytes, not live bytes.
  - mtimecmp bytes are always read live.
- Write: en_in=1, r_nw_in=0 updates the addressed byte at the clock edge.
- Prescaler:
  - Advances only when ctrl.bit0=1 and rdy_in=1.
  - tick = (pcnt == PRESCALE-1). On tick, pcnt→0 and mtime increments by 1; otherwise pcnt increments.
  - mtime wraps from 2^64-1 to 0.
  - ctrl.bit0=0 or rdy_in=0 holds both pcnt and mtime.
- Write/tick collision:
  - A write to any mtime byte in a tick cycle leaves mtime = old value with that byte replaced. The increment is dropped.
  - pcnt still wraps.
- Match:
  - match = (mtime >= mtimecmp), 64-bit unsigned, evaluated on registered values.
  - A rising edge of match while ctrl.bit1=1 sets pending.
  - A match that stays high does not re-set pending after it is cleared.
  - Writing mtimecmp below mtime while ctrl.bit1=1 creates a new rising edge next cycle.
- Clear: irq_ack_in=1 or a status write with d_in[0]=1 clears pending. If a set and a clear occur in the same cycle, the set wins.
- Output: timer_interrupt = registered (pending & ctrl.bit1). It follows pending by one cycle. Clearing ctrl.bit1 masks the output but keeps pending.
- Reset mid-operation forces all reset values immediately, whatever the bus or ack state.

Test Plan:
- Reset, then read 0x00-0x11 → 00 for all bytes except mtimecmp bytes (FF); timer_interrupt=0.
- PRESCALE=4, write ctrl=0x01, wait 40 clk, read mtime → 10 (0x0A), upper bytes 0.
- Preload mtime=0x00000000_FFFFFFFF, enable counting, read 0x00 then 0x04 across a carry → bytes return the pre-carry snapshot 0xFF,...,0x00 with no torn value; a later re-read of 0x00 shows the new value.
- Set mtimecmp=5, ctrl=0x03, PRESCALE=1 → timer_interrupt rises within 2 cycles after mtime reaches 5; pulse irq_ack_in → drops the next cycle and stays 0 while mtime > 5.
- Set mtimecmp=20, then rewrite mtimecmp=10 while mtime=25 with irq enabled → pending re-asserts. Same cycle: a rising match edge and irq_ack_in → pending stays 1.
- Write mtime byte0=0x33 in a tick cycle (mtime was 0x10) → mtime=0x33, not 0x34. Hold rdy_in=0 for 8 cycles → mtime unchanged. Pull rst_n low while pending=1 → timer_interrupt=0 immediately.
